reg_writeback_seq: RTL and testbench

//  Write-side master for RegFile: merges single-cycle ALU results and multi-cycle

---
 rtl/reg_writeback_seq.sv | 89 ++++++++
 tb/tb_reg_writeback_seq.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_writeback_seq.sv
// reg_writeback_seq: merges ALU results and in-order load returns onto one RegFile write port
// Optional same-cycle write forwarding to decode is enabled by defining REG_WB_FORWARD_EN.
module reg_writeback_seq #(
  parameter int W     = 8,
  parameter int A     = 4,
  parameter int DEPTH = 4
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         alu_valid,
  input  logic [A-1:0] alu_addr,
  input  logic [W-1:0] alu_data,
  input  logic         ld_issue,
  input  logic [A-1:0] ld_dest,
  output logic         ld_ready,
  input  logic         mem_rvalid,
  input  logic [W-1:0] mem_rdata,
  output logic         mem_rready,
  input  logic [A-1:0] query_addr,
  output logic         hazard,
  output logic         stall,
  output logic         rf_we,
  output logic [A-1:0] rf_waddr,
  output logic [W-1:0] rf_wdata,
  output logic         fwd_valid,
  output logic [W-1:0] fwd_data,
  output logic         err
);
  localparam int PW = $clog2(DEPTH) + 1;
  localparam int N  = 2 ** A;
  logic [A-1:0]  fifo [DEPTH];
  logic [PW-1:0] wp, rp;
  logic [N-1:0]  pend, pend_nx;
  logic          skid_v;
  logic [A-1:0]  skid_addr;
  logic [W-1:0]  skid_data;
  logic          empty, full, push, ret, alu_go;
  logic [A-1:0]  head;
  assign empty      = wp == rp;
  assign full       = (wp[PW-1] != rp[PW-1]) && (wp[PW-2:0] == rp[PW-2:0]);
  assign head       = fifo[rp[PW-2:0]];
  assign ld_ready   = !full;
  assign mem_rready = !skid_v;
  assign push       = ld_issue & ld_ready;
  assign stall      = skid_v | (alu_valid & pend[alu_addr]);
  assign alu_go     = alu_valid & !stall;
  assign ret        = mem_rvalid & mem_rready & !empty;
  assign rf_we      = skid_v | alu_go | ret;
  assign rf_waddr   = skid_v ? skid_addr : alu_go ? alu_addr : head;
  assign rf_wdata   = skid_v ? skid_data : alu_go ? alu_data : mem_rdata;
`ifdef REG_WB_FORWARD_EN
  assign fwd_valid  = rf_we & (rf_waddr == query_addr);
  assign fwd_data   = rf_wdata;
  assign hazard     = pend[query_addr] & !fwd_valid;
`else
  assign fwd_valid  = 1'b0;
  assign fwd_data   = '0;
  assign hazard     = pend[query_addr];
`endif
  // A load's pending bit clears only when its data actually reaches the port; a new issue wins.
  always_comb begin
    pend_nx = pend;
    if (skid_v) pend_nx[skid_addr] = 1'b0;
    else if (ret && !alu_go) pend_nx[head] = 1'b0;
    if (push) pend_nx[ld_dest] = 1'b1;
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      wp     <= '0;
      rp     <= '0;
      pend   <= '0;
      skid_v <= 1'b0;
      err    <= 1'b0;
    end else begin
      pend   <= pend_nx;
      skid_v <= ret & alu_go;
      err    <= err | (mem_rvalid & mem_rready & empty);
      if (push) begin
        fifo[wp[PW-2:0]] <= ld_dest;
        wp               <= wp + 1'b1;
      end
      if (ret) rp <= rp + 1'b1;
      if (ret && alu_go) begin
        skid_addr <= head;
        skid_data <= mem_rdata;
      end
    end
  end
endmodule

// File: tb/tb_reg_writeback_seq.sv
// tb_reg_writeback_seq: directed vector table, hand sequences and random traffic vs a queue-based model
module tb_reg_writeback_seq;
  localparam int DEPTH = 4;
`ifdef REG_WB_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  logic Clk = 0, Reset = 1;
  logic alu_valid = 0, ld_issue = 0, mem_rvalid = 0;
  logic [3:0] alu_addr = 0, ld_dest = 0, query_addr = 0;
  logic [7:0] alu_data = 0, mem_rdata = 0;
  logic ld_ready, mem_rready, hazard, stall, rf_we, fwd_valid, err;
  logic [3:0] rf_waddr;
  logic [7:0] rf_wdata, fwd_data;
  int n_cmp = 0, n_bad = 0;

  reg_writeback_seq dut (
    .Clk(Clk), .Reset(Reset), .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data),
    .ld_issue(ld_issue), .ld_dest(ld_dest), .ld_ready(ld_ready), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .mem_rready(mem_rready), .query_addr(query_addr), .hazard(hazard),
    .stall(stall), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .fwd_valid(fwd_valid), .fwd_data(fwd_data), .err(err)
  );

  always #5 Clk = ~Clk;

  typedef struct { logic [3:0] a; logic [7:0] d; } wr_t;
  logic [3:0] q_dest[$];
  wr_t        skid_q[$];
  bit         pend_m [16];
  bit         err_m;

  typedef struct {
    logic av; logic [3:0] aa; logic [7:0] ad; logic li; logic [3:0] ld; logic mv; logic [7:0] md;
    logic [3:0] q; logic we; logic [3:0] wa; logic [7:0] wd; logic st, rdy, hz, fw;
  } vec_t;
  vec_t tbl[22];

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", n, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q_dest.delete();
    skid_q.delete();
    foreach (pend_m[i]) pend_m[i] = 0;
    err_m = 0;
  endtask

  // Called just after the inputs change on a negedge; checks, then advances the model across the posedge.
  task automatic step();
    bit rdy, rrdy, st, alu_ok, ret, we, iss, fwd, hz, e_set;
    logic [3:0] wa;
    logic [7:0] wd;
    #1;
    rdy    = q_dest.size() < DEPTH;
    rrdy   = skid_q.size() == 0;
    st     = !rrdy || (alu_valid && pend_m[alu_addr]);
    alu_ok = alu_valid && !st;
    ret    = mem_rvalid && rrdy && q_dest.size() > 0;
    iss    = ld_issue && rdy;
    e_set  = mem_rvalid && rrdy && q_dest.size() == 0;
    we     = !rrdy || alu_ok || ret;
    wa = 0; wd = 0;
    if (!rrdy) begin wa = skid_q[0].a; wd = skid_q[0].d; end
    else if (alu_ok) begin wa = alu_addr; wd = alu_data; end
    else if (ret) begin wa = q_dest[0]; wd = mem_rdata; end
    fwd = FWD && we && wa == query_addr;
    hz  = pend_m[query_addr] && !fwd;
    if (!Reset) begin
      chk("ld_ready", ld_ready, rdy);
      chk("mem_rready", mem_rready, rrdy);
      chk("stall", stall, st);
      chk("rf_we", rf_we, we);
      chk("hazard", hazard, hz);
      chk("fwd_valid", fwd_valid, fwd);
      chk("err", err, err_m);
      if (we) begin
        chk("rf_waddr", rf_waddr, wa);
        chk("rf_wdata", rf_wdata, wd);
      end
      if (fwd) chk("fwd_data", fwd_data, wd);
      else if (!FWD) chk("fwd_data", fwd_data, 0);
    end
    @(posedge Clk);
    if (Reset) model_reset();
    else begin
      if (!rrdy) begin
        pend_m[skid_q[0].a] = 0;
        skid_q.pop_front();
      end
      if (ret) begin
        if (alu_ok) skid_q.push_back('{a: q_dest[0], d: mem_rdata});
        else pend_m[q_dest[0]] = 0;
        void'(q_dest.pop_front());
      end
      if (iss) begin
        pend_m[ld_dest] = 1;
        q_dest.push_back(ld_dest);
      end
      if (e_set) err_m = 1;
    end
    @(negedge Clk);
  endtask

  task automatic drive(input vec_t v);
    alu_valid = v.av; alu_addr = v.aa; alu_data = v.ad; ld_issue = v.li; ld_dest = v.ld;
    mem_rvalid = v.mv; mem_rdata = v.md; query_addr = v.q;
  endtask

  task automatic idle();
    alu_valid = 0; ld_issue = 0; mem_rvalid = 0;
  endtask

  initial begin
    //           av aa ad     li ld mv md     q   we wa wd     st rdy hz fw
    tbl[0]  = '{1, 5, 8'h3C, 0, 0, 0, 8'h00, 0,  1, 5, 8'h3C, 0, 1, 0, 0};
    tbl[1]  = '{0, 0, 8'h00, 1, 1, 0, 8'h00, 1,  0, 0, 8'h00, 0, 1, 0, 0};
    tbl[2]  = '{0, 0, 8'h00, 1, 2, 0, 8'h00, 1,  0, 0, 8'h00, 0, 1, 1, 0};
    tbl[3]  = '{0, 0, 8'h00, 1, 3, 0, 8'h00, 2,  0, 0, 8'h00, 0, 1, 1, 0};
    tbl[4]  = '{0, 0, 8'h00, 1, 4, 0, 8'h00, 3,  0, 0, 8'h00, 0, 1, 1, 0};
    tbl[5]  = '{0, 0, 8'h00, 1, 9, 0, 8'h00, 4,  0, 0, 8'h00, 0, 0, 1, 0};
    tbl[6]  = '{0, 0, 8'h00, 0, 0, 0, 8'h00, 9,  0, 0, 8'h00, 0, 0, 0, 0};
    tbl[7]  = '{0, 0, 8'h00, 0, 0, 1, 8'hAA, 1,  1, 1, 8'hAA, 0, 0, 1, 1};
    tbl[8]  = '{0, 0, 8'h00, 0, 0, 1, 8'hBB, 1,  1, 2, 8'hBB, 0, 1, 0, 0};
    tbl[9]  = '{0, 0, 8'h00, 0, 0, 1, 8'hCC, 2,  1, 3, 8'hCC, 0, 1, 0, 0};
    tbl[10] = '{0, 0, 8'h00, 0, 0, 1, 8'hDD, 4,  1, 4, 8'hDD, 0, 1, 1, 1};
    tbl[11] = '{0, 0, 8'h00, 0, 0, 0, 8'h00, 4,  0, 0, 8'h00, 0, 1, 0, 0};
    tbl[12] = '{0, 0, 8'h00, 1, 2, 0, 8'h00, 0,  0, 0, 8'h00, 0, 1, 0, 0};
    tbl[13] = '{1, 7, 8'h11, 0, 0, 1, 8'h22, 2,  1, 7, 8'h11, 0, 1, 1, 0};
    tbl[14] = '{1, 8, 8'h33, 0, 0, 0, 8'h00, 2,  1, 2, 8'h22, 1, 1, 1, 1};
    tbl[15] = '{1, 8, 8'h33, 0, 0, 0, 8'h00, 2,  1, 8, 8'h33, 0, 1, 0, 0};
    tbl[16] = '{0, 0, 8'h00, 1, 6, 0, 8'h00, 0,  0, 0, 8'h00, 0, 1, 0, 0};
    tbl[17] = '{1, 6, 8'h44, 0, 0, 0, 8'h00, 6,  0, 0, 8'h00, 1, 1, 1, 0};
    tbl[18] = '{1, 6, 8'h44, 0, 0, 0, 8'h00, 6,  0, 0, 8'h00, 1, 1, 1, 0};
    tbl[19] = '{1, 6, 8'h44, 0, 0, 1, 8'h55, 6,  1, 6, 8'h55, 1, 1, 1, 1};
    tbl[20] = '{1, 6, 8'h44, 0, 0, 0, 8'h00, 6,  1, 6, 8'h44, 0, 1, 0, 1};
    tbl[21] = '{0, 0, 8'h00, 0, 0, 1, 8'h77, 0,  0, 0, 8'h00, 0, 1, 0, 0};
    model_reset();
    idle();
    step();
    step();
    Reset = 0;
    #1;
    chk("reset rf_we", rf_we, 0);
    chk("reset stall", stall, 0);
    chk("reset ld_ready", ld_ready, 1);
    chk("reset mem_rready", mem_rready, 1);
    chk("reset hazard", hazard, 0);
    chk("reset err", err, 0);
    step();
    for (int i = 0; i < 22; i++) begin
      drive(tbl[i]);
      #1;
      chk($sformatf("v%0d rf_we", i), rf_we, tbl[i].we);
      if (tbl[i].we) begin
        chk($sformatf("v%0d rf_waddr", i), rf_waddr, tbl[i].wa);
        chk($sformatf("v%0d rf_wdata", i), rf_wdata, tbl[i].wd);
      end
      chk($sformatf("v%0d stall", i), stall, tbl[i].st);
      chk($sformatf("v%0d ld_ready", i), ld_ready, tbl[i].rdy);
      chk($sformatf("v%0d hazard", i), hazard, tbl[i].hz && !(FWD && tbl[i].fw));
      chk($sformatf("v%0d fwd_valid", i), fwd_valid, FWD && tbl[i].fw);
      step();
    end
    idle();
    #1;
    chk("err sticky", err, 1);
    chk("no write on orphan return", rf_we, 0);
    step();
    ld_issue = 1; ld_dest = 3; query_addr = 3;
    step();
    idle();
    #1;
    chk("pend before reset", hazard, 1);
    Reset = 1;
    step();
    Reset = 0;
    #1;
    chk("mid reset hazard", hazard, 0);
    chk("mid reset err", err, 0);
    chk("mid reset ld_ready", ld_ready, 1);
    chk("mid reset mem_rready", mem_rready, 1);
    step();
    mem_rvalid = 1; mem_rdata = 8'h99;
    #1;
    chk("dropped load no write", rf_we, 0);
    step();
    idle();
    #1;
    chk("err after dropped load", err, 1);
    step();
    for (int c = 0; c < 1500; c++) begin
      Reset      = ($urandom_range(0, 199) == 0);
      alu_valid  = $urandom_range(0, 1);
      alu_addr   = 4'($urandom_range(0, 15));
      alu_data   = 8'($urandom);
      ld_issue   = ($urandom_range(0, 2) == 0);
      ld_dest    = 4'($urandom_range(0, 15));
      mem_rvalid = ($urandom_range(0, 2) == 0);
      mem_rdata  = 8'($urandom);
      query_addr = 4'($urandom_range(0, 15));
      step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
